softmax_out_streamer: RTL and testbench

//  Downstream stage of softmax32Elements. After o_done, reads the 32 Q0.16 probabilities

---
 rtl/softmax_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/softmax_out_streamer.sv | 174 +++++++++++++++++
 tb/tb_softmax_out_streamer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// ----------------------------------------------------------------------------
// softmax_pkg
// Shared constants for the softmax output path: row geometry, BRAM/stream
// widths, Q-format fraction bits, the requantization rounding constant and
// the streamer FSM state type.
// ----------------------------------------------------------------------------
package softmax_pkg;

    // Row geometry and datapath widths
    localparam int unsigned N_ELEM     = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned IN_W       = 16;
    localparam int unsigned OUT_W      = 8;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    // Q-format fraction bits used along the softmax pipeline
    localparam int unsigned Q2_14_FRAC = 14;
    localparam int unsigned Q0_16_FRAC = 16;
    localparam int unsigned Q0_8_FRAC  = 8;

    // Q0.16 -> Q0.8: drop 8 fraction bits, rounding half up
    localparam int unsigned       REQ_SHIFT = Q0_16_FRAC - Q0_8_FRAC;
    localparam logic [IN_W:0]     REQ_RND   = 17'h00080;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with combinational head read. Push while full is accepted
// only when a pop happens in the same cycle; pop while empty is ignored.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_din    write request and data
//   i_pop            read request (advances the head)
//   o_dout           current head entry
//   o_full, o_empty  occupancy flags
//   o_count          number of stored entries
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = i_pop && (count != '0);
        do_push = i_push && ((count != CNT_FULL) || do_pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_din;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_dout  = mem[rd_ptr];
    assign o_full  = (count == CNT_FULL);
    assign o_empty = (count == '0);
    assign o_count = count;

endmodule

// File: rtl/softmax_out_streamer.sv
// ----------------------------------------------------------------------------
// softmax_out_streamer
// Reads one softmax row of Q0.16 probabilities from BRAM port B, requantizes
// each to Q0.8 (round half up, saturating) and streams them over valid/ready.
// Reads are credit limited so the skid FIFO can never overflow under
// backpressure. The raw Q0.16 row sum is reported alongside o_done.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 row start pulse (accepted only in IDLE)
//   o_busy                  row in progress
//   o_bram_en, o_bram_addr  BRAM port-B read request
//   i_bram_dout             BRAM port-B data, RD_LAT cycles after request
//   o_data, o_valid, i_ready, o_last   output stream
//   o_sum                   sum of raw words of the current/last row
//   o_done                  one-cycle pulse after the last beat is taken
// ----------------------------------------------------------------------------
module softmax_out_streamer
    import softmax_pkg::*;
#(
    parameter int unsigned N_ELEM     = softmax_pkg::N_ELEM,
    parameter int unsigned ADDR_W     = softmax_pkg::ADDR_W,
    parameter int unsigned IN_W       = softmax_pkg::IN_W,
    parameter int unsigned OUT_W      = softmax_pkg::OUT_W,
    parameter int unsigned RD_LAT     = softmax_pkg::RD_LAT,
    parameter int unsigned FIFO_DEPTH = softmax_pkg::FIFO_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_bram_en,
    output logic [ADDR_W-1:0]      o_bram_addr,
    input  logic [IN_W-1:0]        i_bram_dout,
    output logic [OUT_W-1:0]       o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_last,
    output logic [IN_W+ADDR_W-1:0] o_sum,
    output logic                   o_done
);

    localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned       SHIFT     = IN_W - OUT_W;
    localparam logic [IN_W:0]     RND       = (IN_W + 1)'(1) << (SHIFT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);

    state_t                  state;
    logic [ADDR_W-1:0]       addr_q;
    logic [RD_LAT-1:0]       tag_q;     // one bit per outstanding BRAM read
    logic [RD_LAT-1:0]       last_q;    // marks the read of the final address
    logic [IN_W+ADDR_W-1:0]  sum_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [OUT_W:0]          fifo_din;
    logic [OUT_W:0]          fifo_dout;

    logic [7:0]              in_flight;
    logic [7:0]              credit_used;
    logic                    issue;
    logic [IN_W:0]           rounded;
    logic [IN_W:0]           shifted;
    logic [OUT_W-1:0]        q_sat;

    // Credit: stored entries plus reads still in the BRAM pipe never exceed
    // FIFO_DEPTH, so every returning word has a slot waiting for it.
    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + 8'(tag_q[i]);
        end
        credit_used = 8'(fifo_count) + in_flight;
        issue       = (state == READ) && (credit_used < 8'(FIFO_DEPTH));
    end

    always_comb begin
        rounded = {1'b0, i_bram_dout} + RND;
        shifted = rounded >> SHIFT;
        q_sat   = (|shifted[IN_W:OUT_W]) ? '1 : shifted[OUT_W-1:0];
    end

    assign fifo_push = tag_q[RD_LAT-1];
    assign fifo_din  = {last_q[RD_LAT-1], q_sat};
    assign fifo_pop  = o_valid && i_ready;

    sync_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_din   (fifo_din),
        .i_pop   (fifo_pop),
        .o_dout  (fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            tag_q  <= '0;
            last_q <= '0;
            sum_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tag_q[0]  <= issue;
            last_q[0] <= issue && (addr_q == LAST_ADDR);
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_q[i]  <= tag_q[i-1];
                last_q[i] <= last_q[i-1];
            end

            done_q <= 1'b0;
            if (fifo_push) begin
                sum_q <= sum_q + {{ADDR_W{1'b0}}, i_bram_dout};
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= READ;
                        addr_q <= '0;
                        sum_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                READ: begin
                    // Address holds at the last element instead of wrapping.
                    if (issue) begin
                        if (addr_q == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_pop && fifo_dout[OUT_W]) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_sum       = sum_q;
    assign o_bram_en   = issue;
    assign o_bram_addr = addr_q;
    assign o_valid     = !fifo_empty;
    // The head entry is stale once popped; gate it so idle outputs read 0.
    assign o_data      = o_valid ? fifo_dout[OUT_W-1:0] : '0;
    assign o_last      = o_valid && fifo_dout[OUT_W];

endmodule

// File: tb/tb_softmax_out_streamer.sv
module tb_softmax_out_streamer;
    import softmax_pkg::*;

    localparam int unsigned SUM_W = IN_W + ADDR_W;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_start;
    logic              o_busy;
    logic              o_bram_en;
    logic [ADDR_W-1:0] o_bram_addr;
    logic [IN_W-1:0]   i_bram_dout;
    logic [OUT_W-1:0]  o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_last;
    logic [SUM_W-1:0]  o_sum;
    logic              o_done;

    always #5 i_clk = ~i_clk;

    softmax_out_streamer #(
        .N_ELEM     (N_ELEM),
        .ADDR_W     (ADDR_W),
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_bram_en   (o_bram_en),
        .o_bram_addr (o_bram_addr),
        .i_bram_dout (i_bram_dout),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_last      (o_last),
        .o_sum       (o_sum),
        .o_done      (o_done)
    );

    // BRAM port B with output register: two-cycle read latency
    logic [IN_W-1:0] mem [N_ELEM];
    logic [IN_W-1:0] st1 = '0;
    logic [IN_W-1:0] st2 = '0;
    always @(posedge i_clk) begin
        if (o_bram_en) st1 <= mem[o_bram_addr];
        st2 <= st1;
    end
    assign i_bram_dout = st2;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: expected beats per accepted start
    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      expq[$];
    logic [7:0] beat_log[$];
    logic [SUM_W-1:0] exp_sum = '0;
    int exp_addr = 0;
    int issued   = 0;
    int popped   = 0;
    int en_cnt   = 0;
    int beat_idx = 0;
    int done_cnt = 0;
    int ready_mode = 1;   // 0: low, 1: high, 2: random 30%

    function automatic logic [7:0] rq(input logic [IN_W-1:0] d);
        int v;
        v = (int'(d) + 128) / 256;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    // Caller is #1 after a rising edge; returns #1 after the accepting edge.
    task automatic start_row();
        int s;
        s = 0;
        for (int i = 0; i < N_ELEM; i++) begin
            beat_t b;
            b.data = rq(mem[i]);
            b.last = (i == N_ELEM - 1);
            expq.push_back(b);
            s += int'(mem[i]);
        end
        exp_sum  = SUM_W'(s);
        exp_addr = 0;
        issued   = 0;
        popped   = 0;
        en_cnt   = 0;
        beat_idx = 0;
        beat_log.delete();
        i_start  = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_done && n < 2000);
        chk("done_timeout", 64'(o_done), 64'd1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_ELEM; i++) mem[i] = 16'($urandom);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"},  64'(o_busy), 0);
        chk({tag, "_en"},    64'(o_bram_en), 0);
        chk({tag, "_addr"},  64'(o_bram_addr), 0);
        chk({tag, "_data"},  64'(o_data), 0);
        chk({tag, "_valid"}, 64'(o_valid), 0);
        chk({tag, "_last"},  64'(o_last), 0);
        chk({tag, "_sum"},   64'(o_sum), 0);
        chk({tag, "_done"},  64'(o_done), 0);
    endtask

    // Ready driver
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                0:       i_ready = 1'b0;
                2:       i_ready = ($urandom_range(0, 99) < 30);
                default: i_ready = 1'b1;
            endcase
        end
    end

    // Compare process: every cycle, sampled at the falling edge
    initial begin
        logic       pv, pr, pl;
        logic [7:0] pd;
        beat_t      b;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 64'(o_valid), 1);
                    chk("hold_data",  64'(o_data), 64'(pd));
                    chk("hold_last",  64'(o_last), 64'(pl));
                end
                if (o_bram_en) begin
                    chk("rd_addr", 64'(o_bram_addr), 64'(exp_addr));
                    chk("rd_credit", 64'((issued - popped) < int'(FIFO_DEPTH)), 1);
                    exp_addr++;
                    issued++;
                    en_cnt++;
                end
                if (o_valid && i_ready) begin
                    if (expq.size() == 0) begin
                        chk("stale_beat", 64'(o_data), 64'hDEAD);
                    end else begin
                        b = expq.pop_front();
                        chk("beat_data", 64'(o_data), 64'(b.data));
                        chk("beat_last", 64'(o_last), 64'(b.last));
                    end
                    beat_log.push_back(o_data);
                    beat_idx++;
                    popped++;
                end
                if (o_done) begin
                    done_cnt++;
                    chk("done_sum", 64'(o_sum), 64'(exp_sum));
                    chk("done_all_beats", 64'(expq.size()), 0);
                end
                pv = o_valid; pr = i_ready; pd = o_data; pl = o_last;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0, n, gap, maxgap, seen;
        logic started;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        for (int i = 0; i < N_ELEM; i++) mem[i] = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_outputs_zero("reset");
        @(posedge i_clk); #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // 1: uniform row, full throughput
        for (int i = 0; i < N_ELEM; i++) mem[i] = 16'h0800;
        ready_mode = 1;
        start_row();
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (o_valid) begin lat = k - 1; break; end
            @(posedge i_clk); #1;
            if (o_valid) begin lat = k; break; end
        end
        chk("t1_latency", 64'(lat), 3);
        chk("t1_busy", 64'(o_busy), 1);
        wait_done();
        chk("t1_sum", 64'(o_sum), 64'h10000);
        chk("t1_beats", 64'(beat_idx), 32);
        chk("t1_first_beat", 64'(beat_log[0]), 64'h08);
        chk("t1_last_beat", 64'(beat_log[31]), 64'h08);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("t1_one_done", 64'(done_cnt), 1);

        // 2: rounding and saturation
        fill_random();
        mem[0] = 16'h007F; mem[1] = 16'h0080; mem[2] = 16'h0180; mem[3] = 16'hFFFF;
        start_row();
        wait_done();
        chk("t2_q_007F", 64'(beat_log[0]), 64'h00);
        chk("t2_q_0080", 64'(beat_log[1]), 64'h01);
        chk("t2_q_0180", 64'(beat_log[2]), 64'h02);
        chk("t2_q_FFFF", 64'(beat_log[3]), 64'hFF);
        @(posedge i_clk); #1;

        // 3: random backpressure
        fill_random();
        ready_mode = 2;
        start_row();
        wait_done();
        ready_mode = 1;
        chk("t3_beats", 64'(beat_idx), 32);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;

        // 4: stalled consumer then release
        fill_random();
        ready_mode = 0;
        @(posedge i_clk); #1;
        start_row();
        repeat (19) @(posedge i_clk);
        @(negedge i_clk);
        chk("t4_en_pulses", 64'(en_cnt), 4);
        chk("t4_en_idle", 64'(o_bram_en), 0);
        ready_mode = 1;
        gap = 0; maxgap = 0; seen = 0; started = 1'b0; n = 0;
        while (seen < 28 && n < 500) begin
            @(negedge i_clk);
            n++;
            if (o_bram_en) begin
                if (started && gap > maxgap) maxgap = gap;
                gap = 0;
                started = 1'b1;
                seen++;
            end else if (started) begin
                gap++;
            end
        end
        chk("t4_remaining_reads", 64'(seen), 28);
        chk("t4_gap_ok", 64'(maxgap <= int'(RD_LAT)), 1);
        wait_done();
        chk("t4_total_reads", 64'(en_cnt), 32);
        @(posedge i_clk); #1;

        // 5: ignored starts, then back-to-back row
        fill_random();
        d0 = done_cnt;
        start_row();
        repeat (5) @(posedge i_clk);
        #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
        wait_done();
        i_start = 1'b1;                      // lands on the DONE cycle edge
        @(posedge i_clk); #1 i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("t5_done_start_ignored", 64'({o_busy, o_bram_en}), 0);
        end
        chk("t5_one_done", 64'(done_cnt), 64'(d0 + 1));
        @(posedge i_clk); #1;
        fill_random();
        start_row();
        wait_done();
        @(posedge i_clk); #1;
        fill_random();
        start_row();
        @(negedge i_clk);
        chk("t5_sum_cleared", 64'(o_sum), 0);
        wait_done();
        @(posedge i_clk); #1;
        chk("t5_done_count", 64'(done_cnt), 64'(d0 + 3));

        // 6: reset mid-row, then a clean row
        fill_random();
        d0 = done_cnt;
        start_row();
        n = 0;
        while (beat_idx < 10 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk("t6_reached_beat10", 64'(beat_idx >= 10), 1);
        @(posedge i_clk); #1 i_rst_n = 1'b0;
        expq.delete();
        @(negedge i_clk);
        check_outputs_zero("t6_reset");
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk("t6_no_stale_valid", 64'(o_valid), 0);
        end
        chk("t6_no_partial_done", 64'(done_cnt), 64'(d0));
        @(posedge i_clk); #1;
        fill_random();
        start_row();
        wait_done();
        chk("t6_beats", 64'(beat_idx), 32);
        @(posedge i_clk); #1;
        chk("t6_done_count", 64'(done_cnt), 64'(d0 + 1));

        repeat (3) @(posedge i_clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
